plane_offset_calculator: RTL and testbench

Downstream consumer of the cross-product stage in the plane-fitting path. Takes the plane normal produced by the cross product and one of the three sample points, and computes the plane offset d = -(n · p), emitting the full plane (n, d). The dot product is serialised through a single slow_fp_fused_multiply_add instance as three chained FMA passes. An all-zero normal (collinear samples) is flagged as degenerate and bypasses the FMA.

---
 rtl/plane_offset_calculator.sv | 195 +++++++++++++++++++
 tb/tb_plane_offset_calculator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/plane_offset_calculator.sv
// Plane offset stage: d = -(n . p) via three chained FMA passes on one shared unit.
// Also holds the Q16.16 fixed-point package and the iterative FMA it drives.

package ransac_fixed;
   localparam int FRAC_BITS = 16;

   typedef logic signed [31:0] fixed_t;

   typedef struct packed {
      fixed_t x;
      fixed_t y;
      fixed_t z;
   } vector3f_t;

   typedef enum logic [1:0] {
      FMA_OPCODE_POS_A_POS_C,
      FMA_OPCODE_NEG_A_POS_C,
      FMA_OPCODE_POS_A_NEG_C,
      FMA_OPCODE_NEG_A_NEG_C
   } fma_opcode_t;

   function automatic int value_bits();
      return $bits(fixed_t);
   endfunction
endpackage

// Single-issue fixed-point FMA. A request accepted in cycle t yields
// output_valid (one-cycle pulse) in cycle t + multiply_latency - 1 after the accept edge.
module slow_fp_fused_multiply_add #(
   parameter int multiply_latency = 4,
   parameter bit reset_polarity   = 1'b1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      input_valid,
   output logic                      input_ready,
   input  ransac_fixed::fixed_t      a,
   input  ransac_fixed::fixed_t      b,
   input  ransac_fixed::fixed_t      c,
   input  ransac_fixed::fma_opcode_t opcode,
   output logic                      output_valid,
   output ransac_fixed::fixed_t      result
);
   import ransac_fixed::*;

   localparam int CW = $clog2(multiply_latency + 1);

   logic                 rst_n;
   logic [CW-1:0]        count;
   logic signed [63:0]   a_ext, b_ext, full;
   fixed_t               prod, sum;

   assign rst_n       = reset_polarity ? ~reset : reset;
   assign input_ready = (count == '0);

   always_comb begin
      a_ext = a;
      b_ext = b;
      full  = a_ext * b_ext;
      prod  = fixed_t'(full >>> FRAC_BITS);
      case (opcode)
         FMA_OPCODE_POS_A_POS_C: sum = prod + c;
         FMA_OPCODE_NEG_A_POS_C: sum = c - prod;
         FMA_OPCODE_POS_A_NEG_C: sum = prod - c;
         default:                sum = -prod - c;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         count        <= '0;
         output_valid <= 1'b0;
         result       <= '0;
      end else if (input_valid && input_ready) begin
         result       <= sum;
         count        <= CW'(multiply_latency - 1);
         output_valid <= (multiply_latency == 1);
      end else begin
         output_valid <= (count == CW'(1));
         if (count != '0) count <= count - CW'(1);
      end
   end
endmodule

module plane_offset_calculator #(
   parameter int multiply_latency = ransac_fixed::value_bits() / 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    input_valid,
   input  ransac_fixed::vector3f_t normal,
   input  ransac_fixed::vector3f_t point,
   output logic                    input_ready,
   output logic                    output_valid,
   output ransac_fixed::vector3f_t plane_normal,
   output ransac_fixed::fixed_t    plane_offset,
   output logic                    degenerate
);
   import ransac_fixed::*;

   typedef enum logic [2:0] {IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, ISSUE_Z, WAIT_Z} state_t;

   state_t    state, state_nx;
   vector3f_t n_q, p_q;
   fixed_t    acc;
   fixed_t    fma_a, fma_b, fma_c, fma_r;
   logic      fma_in_valid, fma_ready, fma_out_valid;
   logic      accept, zero_normal, in_wait;

   assign input_ready = (state == IDLE);
   assign accept      = input_valid && input_ready;
   assign zero_normal = (normal == '0);
   assign in_wait     = state inside {WAIT_X, WAIT_Y, WAIT_Z};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && !zero_normal)      state_nx = ISSUE_X;
         ISSUE_X: if (fma_in_valid && fma_ready)   state_nx = WAIT_X;
         WAIT_X:  if (fma_out_valid)               state_nx = ISSUE_Y;
         ISSUE_Y: if (fma_in_valid && fma_ready)   state_nx = WAIT_Y;
         WAIT_Y:  if (fma_out_valid)               state_nx = ISSUE_Z;
         ISSUE_Z: if (fma_in_valid && fma_ready)   state_nx = WAIT_Z;
         WAIT_Z:  if (fma_out_valid)               state_nx = IDLE;
         default:                                  state_nx = IDLE;
      endcase
   end

   // First pass starts the chain from zero; later passes fold in the running sum.
   always_comb begin
      fma_a = n_q.x;
      fma_b = p_q.x;
      fma_c = '0;
      case (state)
         ISSUE_Y, WAIT_Y: begin fma_a = n_q.y; fma_b = p_q.y; fma_c = acc; end
         ISSUE_Z, WAIT_Z: begin fma_a = n_q.z; fma_b = p_q.z; fma_c = acc; end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         n_q          <= '0;
         p_q          <= '0;
         acc          <= '0;
         fma_in_valid <= 1'b0;
         output_valid <= 1'b0;
         plane_normal <= '0;
         plane_offset <= '0;
         degenerate   <= 1'b0;
      end else begin
         // Request stays up for the whole ISSUE state and drops on handshake.
         fma_in_valid <= state_nx inside {ISSUE_X, ISSUE_Y, ISSUE_Z};
         if (in_wait && fma_out_valid) acc <= fma_r;
         if (accept) begin
            n_q <= normal;
            p_q <= point;
            if (zero_normal) begin
               output_valid <= 1'b1;
               plane_normal <= '0;
               plane_offset <= '0;
               degenerate   <= 1'b1;
            end else begin
               output_valid <= 1'b0;
            end
         end else if (state == WAIT_Z && fma_out_valid) begin
            output_valid <= 1'b1;
            plane_normal <= n_q;
            plane_offset <= fma_r;
            degenerate   <= 1'b0;
         end
      end
   end

   slow_fp_fused_multiply_add #(
      .multiply_latency (multiply_latency),
      .reset_polarity   (1'b0)
   ) u_fma (
      .clock        (clock),
      .reset        (reset),
      .input_valid  (fma_in_valid),
      .input_ready  (fma_ready),
      .a            (fma_a),
      .b            (fma_b),
      .c            (fma_c),
      .opcode       (FMA_OPCODE_NEG_A_POS_C),
      .output_valid (fma_out_valid),
      .result       (fma_r)
   );
endmodule

// File: tb/tb_plane_offset_calculator.sv
// Directed bench for plane_offset_calculator: latency, sign/fraction handling,
// degenerate bypass, back-to-back acceptance, mid-job reset and input isolation.
module tb_plane_offset_calculator;
   import ransac_fixed::*;

   localparam int L     = 4;
   localparam int LAT_N = 1 + 3 * (L + 1);

   logic      clock = 1'b0;
   logic      reset = 1'b0;
   logic      input_valid = 1'b0;
   vector3f_t normal = '0;
   vector3f_t point = '0;
   logic      input_ready, output_valid, degenerate;
   vector3f_t plane_normal;
   fixed_t    plane_offset;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   plane_offset_calculator #(.multiply_latency(L)) dut (
      .clock        (clock),
      .reset        (reset),
      .input_valid  (input_valid),
      .normal       (normal),
      .point        (point),
      .input_ready  (input_ready),
      .output_valid (output_valid),
      .plane_normal (plane_normal),
      .plane_offset (plane_offset),
      .degenerate   (degenerate)
   );

   function automatic fixed_t fx(input int i);
      return fixed_t'(i * 65536);
   endfunction

   function automatic vector3f_t vec(input fixed_t x, input fixed_t y, input fixed_t z);
      vector3f_t v;
      v.x = x; v.y = y; v.z = z;
      return v;
   endfunction

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents a pair for one accept edge, then returns 1 step after that edge.
   task automatic start(input vector3f_t n, input vector3f_t p);
      normal = n;
      point = p;
      input_valid = 1'b1;
      @(posedge clock);
      #1;
      input_valid = 1'b0;
   endtask

   // lat = index of the cycle after the accept edge in which output_valid is high.
   task automatic wait_result(input bit scramble, output int lat, output bit saw_fma);
      lat = 1;
      saw_fma = dut.fma_in_valid;
      while (!output_valid && lat < 200) begin
         if (scramble) begin
            normal = vec(fixed_t'($urandom()), fixed_t'($urandom()), fixed_t'($urandom()));
            point  = vec(fixed_t'($urandom()), fixed_t'($urandom()), fixed_t'($urandom()));
            input_valid = 1'($urandom_range(0, 1));
         end
         @(posedge clock);
         #1;
         lat++;
         saw_fma |= dut.fma_in_valid;
      end
      if (scramble) input_valid = 1'b0;
   endtask

   initial begin
      int lat;
      bit saw;
      bit stray;

      // Reset state
      #12;
      check("rst_ready", input_ready, 1'b1);
      check("rst_valid", output_valid, 1'b0);
      check("rst_degen", degenerate, 1'b0);
      check("rst_offset", plane_offset, fx(0));
      check("rst_normal", plane_normal, '0);
      check("rst_fma_valid", dut.fma_in_valid, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // n=(1,2,3) p=(4,5,6) -> -32
      start(vec(fx(1), fx(2), fx(3)), vec(fx(4), fx(5), fx(6)));
      check("j1_busy_ready", input_ready, 1'b0);
      wait_result(1'b0, lat, saw);
      check("j1_latency", lat, LAT_N);
      check("j1_offset", plane_offset, fx(-32));
      check("j1_normal", plane_normal, vec(fx(1), fx(2), fx(3)));
      check("j1_degen", degenerate, 1'b0);
      check("j1_ready", input_ready, 1'b1);
      repeat (3) @(posedge clock);
      #1;
      check("j1_hold_valid", output_valid, 1'b1);
      check("j1_hold_offset", plane_offset, fx(-32));

      // n=(-2,0.5,0) p=(1.5,-4,9) -> 5.0
      start(vec(fx(-2), 32'sh0000_8000, fx(0)), vec(32'sh0001_8000, fx(-4), fx(9)));
      check("j2_valid_drop", output_valid, 1'b0);
      wait_result(1'b0, lat, saw);
      check("j2_latency", lat, LAT_N);
      check("j2_offset", plane_offset, fx(5));
      check("j2_normal", plane_normal, vec(fx(-2), 32'sh0000_8000, fx(0)));

      // Zero normal bypasses the FMA
      start('0, vec(fx(7), fx(7), fx(7)));
      wait_result(1'b0, lat, saw);
      repeat (3) begin
         @(posedge clock);
         #1;
         saw |= dut.fma_in_valid;
      end
      check("deg_latency", lat, 1);
      check("deg_flag", degenerate, 1'b1);
      check("deg_offset", plane_offset, fx(0));
      check("deg_normal", plane_normal, '0);
      check("deg_ready", input_ready, 1'b1);
      check("deg_no_fma", saw, 1'b0);

      // Back-to-back with input_valid held high; second pair changes while first is busy
      normal = vec(fx(0), fx(0), fx(1));
      point = vec(fx(5), fx(7), fx(3));
      input_valid = 1'b1;
      @(posedge clock);
      #1;
      normal = vec(fx(1), fx(0), fx(0));
      point = vec(fx(2), fx(9), fx(9));
      wait_result(1'b0, lat, saw);
      check("b2b1_latency", lat, LAT_N);
      check("b2b1_offset", plane_offset, fx(-3));
      check("b2b1_ready", input_ready, 1'b1);
      @(posedge clock);
      #1;
      input_valid = 1'b0;
      check("b2b_valid_drop", output_valid, 1'b0);
      check("b2b2_accepted", input_ready, 1'b0);
      wait_result(1'b0, lat, saw);
      check("b2b2_latency", lat, LAT_N);
      check("b2b2_offset", plane_offset, fx(-2));
      check("b2b2_normal", plane_normal, vec(fx(1), fx(0), fx(0)));

      // Reset during WAIT_Y
      start(vec(fx(1), fx(2), fx(3)), vec(fx(4), fx(5), fx(6)));
      repeat (7) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_ready", input_ready, 1'b1);
      check("mid_rst_valid", output_valid, 1'b0);
      check("mid_rst_offset", plane_offset, fx(0));
      check("mid_rst_normal", plane_normal, '0);
      check("mid_rst_degen", degenerate, 1'b0);
      check("mid_rst_fma", dut.fma_in_valid, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      stray = 1'b0;
      repeat (20) begin
         @(posedge clock);
         #1;
         stray |= output_valid;
      end
      check("mid_rst_no_result", stray, 1'b0);
      start(vec(fx(1), fx(1), fx(1)), vec(fx(1), fx(1), fx(1)));
      wait_result(1'b0, lat, saw);
      check("post_rst_latency", lat, LAT_N);
      check("post_rst_offset", plane_offset, fx(-3));

      // Inputs scrambled while busy: n=(3,-1,2) p=(2,4,-5) -> 8
      start(vec(fx(3), fx(-1), fx(2)), vec(fx(2), fx(4), fx(-5)));
      wait_result(1'b1, lat, saw);
      check("scr_latency", lat, LAT_N);
      check("scr_offset", plane_offset, fx(8));
      check("scr_normal", plane_normal, vec(fx(3), fx(-1), fx(2)));
      check("scr_degen", degenerate, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
